// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared widths, divider handshake constants and FSM state encoding used by
// the execute-stage divide sequencer (div_ctrl).
//   RegBus        : general register width (32)
//   DoubleRegBus  : divider result width {remainder, quotient} (64)
//   DivStart/Stop : levels of the divider start strobe
//   DivResReady   : level of the divider ready flag when a result is valid
//   div_ctrl_state_t : IDLE / BUSY / DONE sequencer states (2 bits)
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic DivStart    = 1'b1;
  localparam logic DivStop     = 1'b0;
  localparam logic DivResReady = 1'b1;

  typedef enum logic [1:0] {
    DivCtrlIdle = 2'b00,
    DivCtrlBusy = 2'b01,
    DivCtrlDone = 2'b10
  } div_ctrl_state_t;

endpackage

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Execute-stage sequencer for the iterative divider. Issues a DIV/DIVU held in
// EX to the divider exactly once, stalls the pipeline while the divide runs,
// and presents the {remainder, quotient} result to the HI/LO write path. A
// flush annuls an in-flight divide; a downstream stall holds the result.
//
// Ports
//   clk            rising-edge clock
//   Rst_n          synchronous reset, active high (1 = reset)
//   div_req_i      EX holds a DIV/DIVU (held for as long as it sits in EX)
//   div_signed_i   1 = DIV, 0 = DIVU
//   reg1_i/reg2_i  dividend / divisor from the register file
//   flush_i        pipeline flush (exception or eret)
//   ex_stall_i     EX/MEM latch held by a later stage
//   div_start_o    divider start strobe
//   div_annul_o    divider annul (one cycle, on flush during a divide)
//   div_signed_o   divider signed select
//   div_opdata1_o  dividend to the divider
//   div_opdata2_o  divisor to the divider
//   div_result_i   divider result {remainder, quotient}
//   div_ready_i    divider result valid
//   stallreq_o     stall request to the pipeline controller
//   whilo_o        HI/LO write enable
//   hi_o / lo_o    remainder / quotient to HI/LO
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    Rst_n,
  input  logic                    div_req_i,
  input  logic                    div_signed_i,
  input  logic [RegBus-1:0]       reg1_i,
  input  logic [RegBus-1:0]       reg2_i,
  input  logic                    flush_i,
  input  logic                    ex_stall_i,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [RegBus-1:0]       div_opdata1_o,
  output logic [RegBus-1:0]       div_opdata2_o,
  input  logic [DoubleRegBus-1:0] div_result_i,
  input  logic                    div_ready_i,
  output logic                    stallreq_o,
  output logic                    whilo_o,
  output logic [RegBus-1:0]       hi_o,
  output logic [RegBus-1:0]       lo_o
);

  div_ctrl_state_t         state_reg, state_next;
  logic [RegBus-1:0]       op1_reg, op2_reg;
  logic                    signed_reg;
  logic [DoubleRegBus-1:0] result_reg;

  logic issue;
  logic result_valid;

  // Issue only from IDLE; a flushed request never reaches the divider.
  assign issue        = (state_reg == DivCtrlIdle) && div_req_i && !flush_i;
  // Flush takes priority over a result arriving in the same cycle.
  assign result_valid = (state_reg == DivCtrlBusy) && !flush_i &&
                        (div_ready_i == DivResReady);

  always_ff @(posedge clk) begin
    if (Rst_n) begin
      state_reg  <= DivCtrlIdle;
      op1_reg    <= '0;
      op2_reg    <= '0;
      signed_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        op1_reg    <= reg1_i;
        op2_reg    <= reg2_i;
        signed_reg <= div_signed_i;
      end
      if (result_valid) begin
        result_reg <= div_result_i;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_start_o   = DivStop;
    div_annul_o   = 1'b0;
    div_signed_o  = 1'b0;
    div_opdata1_o = '0;
    div_opdata2_o = '0;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    hi_o          = '0;
    lo_o          = '0;

    case (state_reg)
      DivCtrlIdle: begin
        // Operands come straight from the inputs so the divider samples the
        // right values in the issue cycle itself.
        if (issue) begin
          div_start_o   = DivStart;
          stallreq_o    = 1'b1;
          div_signed_o  = div_signed_i;
          div_opdata1_o = reg1_i;
          div_opdata2_o = reg2_i;
          state_next    = DivCtrlBusy;
        end
      end

      DivCtrlBusy: begin
        div_signed_o  = signed_reg;
        div_opdata1_o = op1_reg;
        div_opdata2_o = op2_reg;
        div_start_o   = DivStart;
        stallreq_o    = 1'b1;
        if (flush_i) begin
          div_start_o = DivStop;
          div_annul_o = 1'b1;
          stallreq_o  = 1'b0;
          state_next  = DivCtrlIdle;
        end else if (div_ready_i == DivResReady) begin
          div_start_o = DivStop;
          stallreq_o  = 1'b0;
          whilo_o     = 1'b1;
          hi_o        = div_result_i[DoubleRegBus-1:RegBus];
          lo_o        = div_result_i[RegBus-1:0];
          state_next  = ex_stall_i ? DivCtrlDone : DivCtrlIdle;
        end
      end

      DivCtrlDone: begin
        // The divider has already dropped its result; replay the captured
        // copy while the write is held. div_req_i is still the same
        // instruction here, so it must not start another divide.
        div_signed_o  = signed_reg;
        div_opdata1_o = op1_reg;
        div_opdata2_o = op2_reg;
        whilo_o       = 1'b1;
        hi_o          = result_reg[DoubleRegBus-1:RegBus];
        lo_o          = result_reg[RegBus-1:0];
        if (flush_i || !ex_stall_i) begin
          state_next = DivCtrlIdle;
        end
      end

      default: begin
        state_next = DivCtrlIdle;
      end
    endcase

    // Outputs are forced quiet for the whole reset cycle.
    if (Rst_n) begin
      div_start_o   = DivStop;
      div_annul_o   = 1'b0;
      div_signed_o  = 1'b0;
      div_opdata1_o = '0;
      div_opdata2_o = '0;
      stallreq_o    = 1'b0;
      whilo_o       = 1'b0;
      hi_o          = '0;
      lo_o          = '0;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        div_req_i, div_signed_i, flush_i, ex_stall_i;
  logic [31:0] reg1_i, reg2_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk          (clk),
    .Rst_n        (Rst_n),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .reg1_i       (reg1_i),
    .reg2_i       (reg2_i),
    .flush_i      (flush_i),
    .ex_stall_i   (ex_stall_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // Behavioural iterative divider: samples operands on the start edge, is
  // ready in cycle T+35 (T+3 for a zero divisor), frees itself once start
  // drops, and returns to idle on annul or reset.
  logic        dv_busy;
  int          dv_cnt;
  logic [31:0] dv_a, dv_b;
  logic        dv_sgn;
  logic [31:0] dv_q, dv_r;

  always_ff @(posedge clk) begin
    if (Rst_n) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_a    <= '0;
      dv_b    <= '0;
      dv_sgn  <= 1'b0;
    end else if (!dv_busy) begin
      if (div_start_o) begin
        dv_busy <= 1'b1;
        dv_cnt  <= 1;
        dv_a    <= div_opdata1_o;
        dv_b    <= div_opdata2_o;
        dv_sgn  <= div_signed_o;
      end
    end else if (div_annul_o) begin
      dv_busy <= 1'b0;
    end else if (div_ready_i) begin
      if (!div_start_o) dv_busy <= 1'b0;
    end else begin
      dv_cnt <= dv_cnt + 1;
    end
  end

  assign div_ready_i = dv_busy && (dv_cnt == ((dv_b == 32'd0) ? 3 : 35));

  always_comb begin
    dv_q = '0;
    dv_r = '0;
    if (dv_b != 32'd0) begin
      if (dv_sgn) begin
        dv_q = $signed(dv_a) / $signed(dv_b);
        dv_r = $signed(dv_a) % $signed(dv_b);
      end else begin
        dv_q = dv_a / dv_b;
        dv_r = dv_a % dv_b;
      end
    end
  end

  // Result is only driven while valid, so a stale replay would show up.
  assign div_result_i = div_ready_i ? {dv_r, dv_q} : 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},    div_start_o,   0);
    check({tag, "_annul"},    div_annul_o,   0);
    check({tag, "_signed"},   div_signed_o,  0);
    check({tag, "_op1"},      div_opdata1_o, 0);
    check({tag, "_op2"},      div_opdata2_o, 0);
    check({tag, "_stallreq"}, stallreq_o,    0);
    check({tag, "_whilo"},    whilo_o,       0);
    check({tag, "_hi"},       hi_o,          0);
    check({tag, "_lo"},       lo_o,          0);
  endtask

  // Issue one divide and wait (bounded) for its whilo pulse. Leaves the
  // simulation in the ready cycle unless gap is set.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int estall, input bit gap);
    int stalls;
    bit seen;
    step();
    div_req_i = 1'b1; div_signed_i = sgn; reg1_i = a; reg2_i = b;
    flush_i = 1'b0; ex_stall_i = 1'b0;
    #2;
    check({tag, "_issue_start"}, div_start_o, 1);
    check({tag, "_issue_op1"}, div_opdata1_o, a);
    stalls = 0;
    seen   = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin step(); #2; end
      if (whilo_o) begin seen = 1; break; end
      if (stallreq_o) stalls++;
    end
    check({tag, "_ready_seen"}, seen, 1);
    check({tag, "_stall_cycles"}, stalls, estall);
    check({tag, "_hi"}, hi_o, ehi);
    check({tag, "_lo"}, lo_o, elo);
    check({tag, "_ready_stallreq"}, stallreq_o, 0);
    check({tag, "_ready_start"}, div_start_o, 0);
    $display("div %s a=%h b=%h signed=%0d -> hi=%h lo=%h stall=%0d", tag, a, b, sgn, hi_o, lo_o, stalls);
    if (gap) begin
      step();
      div_req_i = 1'b0;
      #2;
      check({tag, "_post_whilo"}, whilo_o, 0);
      check({tag, "_post_stallreq"}, stallreq_o, 0);
    end
  endtask

  initial begin
    Rst_n = 1'b1; div_req_i = 1'b1; div_signed_i = 1'b1;
    reg1_i = 32'h1234; reg2_i = 32'h5; flush_i = 1'b0; ex_stall_i = 1'b0;
    step(); step();
    #2;
    check_all_zero("reset");
    $display("reset: outputs quiet with request held");
    step();
    Rst_n = 1'b0; div_req_i = 1'b0;

    // Signed divide, then a back-to-back unsigned divide with no idle cycle.
    run_div("div_signed", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, 1'b0);
    run_div("divu", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002,
            32'h0000_0001, 32'h7FFF_FFFC, 35, 1'b1);

    // Divide by zero.
    run_div("div_zero", 1'b1, 32'd100, 32'd0, 32'd0, 32'd0, 3, 1'b1);

    // Flush in T+10.
    step();
    div_req_i = 1'b1; div_signed_i = 1'b1; reg1_i = 32'd50; reg2_i = 32'd7;
    for (int k = 1; k <= 10; k++) step();
    flush_i = 1'b1;
    #2;
    check("flush_annul", div_annul_o, 1);
    check("flush_start", div_start_o, 0);
    check("flush_stallreq", stallreq_o, 0);
    check("flush_whilo", whilo_o, 0);
    step();
    flush_i = 1'b0; div_req_i = 1'b0;
    #2;
    check("flush_next_annul", div_annul_o, 0);
    check("flush_next_start", div_start_o, 0);
    check("flush_next_stallreq", stallreq_o, 0);
    $display("flush: divide annulled in T+10");
    run_div("after_flush", 1'b0, 32'd7, 32'd2, 32'd1, 32'd3, 35, 1'b1);

    // Downstream stall around ready: 20/6 -> q=3 r=2.
    run_div("exstall", 1'b1, 32'd20, 32'd6, 32'd2, 32'd3, 35, 1'b0);
    ex_stall_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      ex_stall_i = (k < 4);
      #2;
      check($sformatf("exstall_hold%0d_whilo", k), whilo_o, 1);
      check($sformatf("exstall_hold%0d_hi", k), hi_o, 32'd2);
      check($sformatf("exstall_hold%0d_lo", k), lo_o, 32'd3);
      check($sformatf("exstall_hold%0d_start", k), div_start_o, 0);
      check($sformatf("exstall_hold%0d_stallreq", k), stallreq_o, 0);
    end
    step();
    div_req_i = 1'b0; ex_stall_i = 1'b0;
    #2;
    check("exstall_release_whilo", whilo_o, 0);
    check("exstall_release_start", div_start_o, 0);
    $display("exstall: result held 5 cycles");

    // Reset in T+20 of a divide.
    step();
    div_req_i = 1'b1; div_signed_i = 1'b1; reg1_i = 32'd81; reg2_i = 32'd4;
    for (int k = 1; k <= 20; k++) step();
    Rst_n = 1'b1;
    #2;
    check("midreset_whilo", whilo_o, 0);
    check("midreset_stallreq", stallreq_o, 0);
    step();
    Rst_n = 1'b0; div_req_i = 1'b0;
    #2;
    check_all_zero("after_reset");
    $display("reset: divide abandoned in T+20");
    run_div("post_reset", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 35, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage sequencer for the iterative divider. Accepts a decoded DIV/DIVU from the ID/EX latch and issues it to the divider. It raises a pipeline stall request for the whole divide, then hands the 64-bit quotient/remainder to the HI/LO write path. It also handles pipeline flush (annul) and downstream stalls, so the same instruction is never issued twice.

## Interface
Parameters: none. Widths come from the shared defines (`RegBus` = 32, `DoubleRegBus` = 64).

Ports:
- clk  in  1  rising-edge clock.
- Rst_n  in  1  reset. One clock; reset is synchronous and active-high (asserted = 1).
- div_req_i  in  1  EX holds a DIV/DIVU this cycle. Stays high for as long as the instruction sits in EX.
- div_signed_i  in  1  1 = DIV, 0 = DIVU.
- reg1_i  in  32  dividend (rs).
- reg2_i  in  32  divisor (rt).
- flush_i  in  1  pipeline flush (exception or eret).
- ex_stall_i  in  1  EX/MEM latch held by a later stage this cycle.
- div_start_o  out  1  divider start (`DivStart`/`DivStop`).
- div_annul_o  out  1  divider annul.
- div_signed_o  out  1  divider signed select.
- div_opdata1_o  out  32  dividend to the divider.
- div_opdata2_o  out  32  divisor to the divider.
- div_result_i  in  64  divider result: {remainder, quotient}.
- div_ready_i  in  1  divider result valid.
- stallreq_o  out  1  stall request to the pipeline controller.
- whilo_o  out  1  HI/LO write enable.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.

## Operation
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE and clears the latched operands, signed flag and result copy.
- IDLE:
  - If div_req_i=1 and flush_i=0: latch reg1_i, reg2_i and div_signed_i; drive start=1; stallreq=1; go to BUSY.
  - The divider operand and signed outputs are muxed combinationally from the inputs in IDLE and from the latched copies otherwise, so the divider samples correct values in the issue cycle.
- BUSY:
  - Default: start=1 and stallreq=1.
  - If flush_i=1: start=0, annul=1 for this cycle only, stallreq=0, no write, go to IDLE. Flush wins over div_ready_i arriving in the same cycle.
  - Else if div_ready_i=1: start=0 (`DivStop`), stallreq=0. whilo=1 with hi=div_result_i[63:32] and lo=div_result_i[31:0], driven combinationally. The result is also captured into a register. Next state is DONE if ex_stall_i=1, otherwise IDLE.
- DONE:
  - Drive whilo=1 and hi/lo from the captured register; start=0; stallreq=0.
  - Ignore div_req_i here; it still belongs to the same instruction.
  - If flush_i=1 or ex_stall_i=0, go to IDLE.
- All outputs not listed above are 0. This includes every output during and after reset, and annul everywhere outside the BUSY flush case.
- Sign correction and divide-by-zero are handled inside the divider. A zero divisor yields hi=lo=0 and is written normally.
- Reset during BUSY: the block returns to IDLE with no write. The divider shares Rst_n and resets with it.

## Timing
- stallreq_o, div_start_o, div_annul_o, whilo_o, hi_o and lo_o are combinational from state and inputs. The state register and the latched data update on the clk edge.
- Normal divide, request first seen in cycle T:
  - stallreq_o is high in T..T+34.
  - div_ready_i is seen in T+35; stallreq_o=0 and whilo_o=1 in T+35.
  - The divider returns to free in T+36.
  - A back-to-back divide may issue in T+36.
- Divide by zero: ready in T+3; stallreq_o is high in T..T+2.
- With ex_stall_i held for N cycles after ready, whilo_o/hi_o/lo_o stay constant for N more cycles.

## Structure
- State encodings `DivCtrlIdle`, `DivCtrlBusy` and `DivCtrlDone` (2 bits) go in define.v, alongside the existing `DivStart`/`DivStop`/`DivResReady` constants.
- No sub-module: this is a single FSM plus operand and result registers. The bench instantiates it together with the divider.

## Test plan
- DIV 0xFFFFFFF9 / 0x00000002, signed, no stalls -> stallreq high for exactly 35 cycles, then one whilo pulse with lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0xFFFFFFF9 / 0x00000002 -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV 100 / 0 -> stallreq for 3 cycles, then whilo=1 with hi=lo=0.
- flush_i pulsed in cycle T+10 of a divide -> annul=1 and start=0 in that cycle only, no whilo, IDLE next cycle. A fresh DIVU 7/2 issued in T+12 returns lo=3, hi=1.
- ex_stall_i held for 4 cycles around ready while div_req_i stays high -> whilo held for 5 cycles with stable hi/lo, and start is never reasserted.
- Rst_n asserted in T+20 of a divide -> every output is 0 in the next cycle, no whilo. After reset is released, DIV 9/3 gives lo=3, hi=0.
